ahb_master: RTL and testbench

- Single-outstanding AHB-Lite initiator that turns a core-side load/store strobe into one NONSEQ transfer on the shared AHB bus.
- Sits between a core or cache data port and the AHB mux/interconnect; it is the requesting end of the bus that memory_control-class slaves answer.
- Performs lane steering for byte/halfword writes and reads, detects misaligned requests locally, and reports slave error responses back to the requester.

---
 rtl/ahb_master_if.sv | 34 +++
 rtl/ahb_master.sv | 130 +++++++++++++
 tb/tb_ahb_master.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_master_if.sv
// Bundle of core-side request strobe and AHB-Lite bus signals for ahb_master.
// master: the initiator's view; slave: the view of whoever drives requests and answers the bus.
interface ahb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              req_write;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic [1:0]        hsize;
  logic              hwrite;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    input  req, req_write, req_size, req_addr, req_wdata, hrdata, hready, hresp,
    output busy, done, err, rdata, haddr, htrans, hsize, hwrite, hwdata
  );

  modport slave (
    output req, req_write, req_size, req_addr, req_wdata, hrdata, hready, hresp,
    input  busy, done, err, rdata, haddr, htrans, hsize, hwrite, hwdata
  );
endinterface

// File: rtl/ahb_master.sv
// Single-outstanding AHB-Lite initiator: one core load/store becomes one NONSEQ transfer,
// with byte-lane steering, local misalignment detection and error reporting.
module ahb_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       nrst,
  ahb_master_if.master bus,
  output logic [1:0] dbg_state
);

  // Handshake: req is sampled only in IDLE (busy=0); done is a one-cycle pulse that
  // lands in an IDLE cycle, so a new req may be presented alongside done.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10,
    S_LERR = 2'b11
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              sticky_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic              misalign;
  logic              accept;
  logic              complete;
  logic [4:0]        req_shamt;
  logic [4:0]        rd_shamt;
  logic [DATA_W-1:0] rd_shifted;
  logic [DATA_W-1:0] rd_masked;

  assign accept    = (state == S_IDLE) && bus.req;
  assign complete  = (state == S_DATA) && bus.hready;
  assign req_shamt = {bus.req_addr[1:0], 3'b000};
  assign rd_shamt  = {addr_q[1:0], 3'b000};

  always_comb begin
    misalign = 1'b0;
    case (bus.req_size)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = bus.req_addr[0];
      2'b10:   misalign = |bus.req_addr[1:0];
      default: misalign = 1'b1;
    endcase
  end

  // Load data arrives on the lane selected by the low address bits.
  always_comb begin
    rd_shifted = bus.hrdata >> rd_shamt;
    rd_masked  = rd_shifted;
    case (size_q)
      2'b00:   rd_masked = rd_shifted & {{(DATA_W-8){1'b0}}, 8'hFF};
      2'b01:   rd_masked = rd_shifted & {{(DATA_W-16){1'b0}}, 16'hFFFF};
      default: rd_masked = rd_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.req) state_nxt = misalign ? S_LERR : S_ADDR;
      S_ADDR: if (bus.hready) state_nxt = S_DATA;
      S_DATA: if (bus.hready) state_nxt = S_IDLE;
      S_LERR: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q   <= '0;
      size_q   <= 2'b00;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        addr_q  <= bus.req_addr;
        size_q  <= bus.req_size;
        write_q <= bus.req_write;
        wdata_q <= bus.req_wdata << req_shamt;
      end
      // hresp in the address phase is a stale response and is ignored.
      if (complete) begin
        done_q   <= 1'b1;
        err_q    <= sticky_q | bus.hresp;
        rdata_q  <= write_q ? '0 : rd_masked;
        sticky_q <= 1'b0;
      end else if (state == S_DATA && bus.hresp) begin
        sticky_q <= 1'b1;
      end
      if (state == S_LERR) begin
        done_q  <= 1'b1;
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;
  assign bus.haddr  = addr_q;
  assign bus.htrans = (state == S_ADDR) ? 2'b10 : 2'b00;
  assign bus.hsize  = size_q;
  assign bus.hwrite = write_q;
  assign bus.hwdata = wdata_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_ahb_master.sv
// Directed bench for ahb_master: bench drives the request side and plays the AHB slave.
module tb_ahb_master;

  logic       clk;
  logic       nrst;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_fail;

  ahb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic w, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd);
    bus.req       = 1'b1;
    bus.req_write = w;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = wd;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0h want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %0h want 0", bus.done); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %0h want 0", bus.err); end
    n_cmp++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", bus.rdata); end
    n_cmp++; if (bus.haddr !== 32'h0) begin n_fail++; $display("FAIL rst_haddr got %h want 0", bus.haddr); end
    n_cmp++; if (bus.htrans !== 2'b00) begin n_fail++; $display("FAIL rst_htrans got %b want 00", bus.htrans); end
    n_cmp++; if (bus.hsize !== 2'b00) begin n_fail++; $display("FAIL rst_hsize got %b want 00", bus.hsize); end
    n_cmp++; if (bus.hwrite !== 1'b0) begin n_fail++; $display("FAIL rst_hwrite got %0h want 0", bus.hwrite); end
    n_cmp++; if (bus.hwdata !== 32'h0) begin n_fail++; $display("FAIL rst_hwdata got %h want 0", bus.hwdata); end
    n_cmp++; if (dbg_state !== 2'b00) begin n_fail++; $display("FAIL rst_state got %b want 00", dbg_state); end
    next_cycle();
    nrst = 1'b1;
    next_cycle();
  endtask

  task automatic test_word_read();
    bus.hrdata = 32'hDEADBEEF;
    drive_req(1'b0, 2'b10, 32'h100, 32'h0);
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL wr_c0_busy got %0h want 0", bus.busy); end
    next_cycle();
    bus.req = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.htrans !== 2'b10) begin n_fail++; $display("FAIL wr_c1_htrans got %b want 10", bus.htrans); end
    n_cmp++; if (bus.haddr !== 32'h100) begin n_fail++; $display("FAIL wr_c1_haddr got %h want 100", bus.haddr); end
    n_cmp++; if (bus.hsize !== 2'b10) begin n_fail++; $display("FAIL wr_c1_hsize got %b want 10", bus.hsize); end
    n_cmp++; if (bus.hwrite !== 1'b0) begin n_fail++; $display("FAIL wr_c1_hwrite got %0h want 0", bus.hwrite); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL wr_c1_busy got %0h want 1", bus.busy); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (bus.htrans !== 2'b00) begin n_fail++; $display("FAIL wr_c2_htrans got %b want 00", bus.htrans); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL wr_c2_done got %0h want 0", bus.done); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL wr_c3_done got %0h want 1", bus.done); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL wr_c3_err got %0h want 0", bus.err); end
    n_cmp++; if (bus.rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_c3_rdata got %h want deadbeef", bus.rdata); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL wr_c3_busy got %0h want 0", bus.busy); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL wr_c4_done got %0h want 0", bus.done); end
    next_cycle();
  endtask

  task automatic test_byte_write();
    bus.hrdata = 32'hFFFFFFFF;
    drive_req(1'b1, 2'b00, 32'h203, 32'h000000A5);
    next_cycle();
    bus.req = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.htrans !== 2'b10) begin n_fail++; $display("FAIL bw_htrans got %b want 10", bus.htrans); end
    n_cmp++; if (bus.haddr !== 32'h203) begin n_fail++; $display("FAIL bw_haddr got %h want 203", bus.haddr); end
    n_cmp++; if (bus.hsize !== 2'b00) begin n_fail++; $display("FAIL bw_hsize got %b want 00", bus.hsize); end
    n_cmp++; if (bus.hwrite !== 1'b1) begin n_fail++; $display("FAIL bw_hwrite got %0h want 1", bus.hwrite); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (bus.hwdata !== 32'hA5000000) begin n_fail++; $display("FAIL bw_hwdata got %h want a5000000", bus.hwdata); end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL bw_done got %0h want 1", bus.done); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL bw_err got %0h want 0", bus.err); end
    n_cmp++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL bw_rdata got %h want 0", bus.rdata); end
    next_cycle();
  endtask

  task automatic test_half_read_wait();
    bus.hrdata = 32'h1234ABCD;
    drive_req(1'b0, 2'b01, 32'h302, 32'h0);
    next_cycle();
    bus.req = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.hsize !== 2'b01) begin n_fail++; $display("FAIL hr_hsize got %b want 01", bus.hsize); end
    for (int c = 2; c <= 4; c++) begin
      next_cycle();
      bus.hready = (c == 4);
      @(negedge clk);
      n_cmp++; if (bus.htrans !== 2'b00) begin n_fail++; $display("FAIL hr_c%0d_htrans got %b want 00", c, bus.htrans); end
      n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL hr_c%0d_done got %0h want 0", c, bus.done); end
    end
    next_cycle();
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL hr_c5_done got %0h want 1", bus.done); end
    n_cmp++; if (bus.rdata !== 32'h00001234) begin n_fail++; $display("FAIL hr_c5_rdata got %h want 00001234", bus.rdata); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL hr_c5_err got %0h want 0", bus.err); end
    next_cycle();
  endtask

  task automatic test_error_resp();
    bus.hrdata = 32'h0;
    drive_req(1'b0, 2'b10, 32'h400, 32'h0);
    next_cycle();
    bus.req = 1'b0;
    next_cycle();
    bus.hresp  = 1'b1;
    bus.hready = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL er_c2_done got %0h want 0", bus.done); end
    next_cycle();
    bus.hready = 1'b1;
    next_cycle();
    bus.hresp = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL er_c4_done got %0h want 1", bus.done); end
    n_cmp++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL er_c4_err got %0h want 1", bus.err); end
    next_cycle();
    // Follow-up read; a stale hresp during its address phase must not flag an error.
    drive_req(1'b0, 2'b10, 32'h404, 32'h0);
    next_cycle();
    bus.req   = 1'b0;
    bus.hresp = 1'b1;
    next_cycle();
    bus.hresp  = 1'b0;
    bus.hrdata = 32'h55AA55AA;
    next_cycle();
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL er2_done got %0h want 1", bus.done); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL er2_err got %0h want 0", bus.err); end
    n_cmp++; if (bus.rdata !== 32'h55AA55AA) begin n_fail++; $display("FAIL er2_rdata got %h want 55aa55aa", bus.rdata); end
    next_cycle();
  endtask

  task automatic test_misalign();
    logic [1:0]  sz_tab [3] = '{2'b10, 2'b11, 2'b01};
    logic [31:0] ad_tab [3] = '{32'h102, 32'h100, 32'h301};
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, sz_tab[i], ad_tab[i], 32'h0);
      next_cycle();
      bus.req = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.htrans !== 2'b00) begin n_fail++; $display("FAIL ma%0d_htrans got %b want 00", i, bus.htrans); end
      n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL ma%0d_busy got %0h want 1", i, bus.busy); end
      n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL ma%0d_c1_done got %0h want 0", i, bus.done); end
      next_cycle();
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL ma%0d_done got %0h want 1", i, bus.done); end
      n_cmp++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL ma%0d_err got %0h want 1", i, bus.err); end
      n_cmp++; if (bus.rdata !== 32'h0) begin n_fail++; $display("FAIL ma%0d_rdata got %h want 0", i, bus.rdata); end
      n_cmp++; if (bus.htrans !== 2'b00) begin n_fail++; $display("FAIL ma%0d_c2_htrans got %b want 00", i, bus.htrans); end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    drive_req(1'b0, 2'b10, 32'h500, 32'h0);
    bus.hready = 1'b0;
    next_cycle();
    bus.req = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.htrans !== 2'b10) begin n_fail++; $display("FAIL rm_pre_htrans got %b want 10", bus.htrans); end
    #2;
    nrst = 1'b0;
    #1;
    n_cmp++; if (bus.htrans !== 2'b00) begin n_fail++; $display("FAIL rm_htrans got %b want 00", bus.htrans); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy got %0h want 0", bus.busy); end
    next_cycle();
    nrst       = 1'b1;
    bus.hready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rm_post%0d_done got %0h want 0", c, bus.done); end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3] = '{32'h11112222, 32'h33334444, 32'h55556666};
    for (int k = 0; k < 3; k++) begin
      drive_req(1'b0, 2'b10, 32'h600 + 32'(4 * k), 32'h0);
      @(negedge clk);
      if (k > 0) begin
        n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL bb%0d_done got %0h want 1", k, bus.done); end
        n_cmp++; if (bus.rdata !== vals[k-1]) begin n_fail++; $display("FAIL bb%0d_rdata got %h want %h", k, bus.rdata, vals[k-1]); end
      end
      next_cycle();
      bus.req = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.htrans !== 2'b10) begin n_fail++; $display("FAIL bb%0d_htrans got %b want 10", k, bus.htrans); end
      n_cmp++; if (bus.haddr !== 32'h600 + 32'(4 * k)) begin n_fail++; $display("FAIL bb%0d_haddr got %h want %h", k, bus.haddr, 32'h600 + 32'(4 * k)); end
      next_cycle();
      bus.hrdata = vals[k];
      next_cycle();
    end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL bb3_done got %0h want 1", bus.done); end
    n_cmp++; if (bus.rdata !== vals[2]) begin n_fail++; $display("FAIL bb3_rdata got %h want %h", bus.rdata, vals[2]); end
    next_cycle();
  endtask

  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    nrst          = 1'b0;
    bus.req       = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
    bus.hrdata    = 32'h0;
    bus.hready    = 1'b1;
    bus.hresp     = 1'b0;
    test_reset();
    test_word_read();
    test_byte_write();
    test_half_read_wait();
    test_error_resp();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
